// File: rtl/student_arb_pkg.sv
// rtl/student_arb_pkg.sv - shared constants and state encoding for the round-robin arbiter
// Contents: ARB_N (requester count), ARB_IDW (owner index width), arb_state_e (IDLE/GRANT).
package student_arb_pkg;
  localparam int ARB_N   = 8;
  localparam int ARB_IDW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/student_rr_arb8_if.sv
// rtl/student_rr_arb8_if.sv - request/grant bundle between requesters and the arbiter
// Signals: req[7:0] (requesters -> arbiter), gnt[7:0], gnt_valid, gnt_id[2:0] (arbiter -> requesters).
// Modports: master (requester side), slave (arbiter side).
interface student_rr_arb8_if;
  import student_arb_pkg::*;

  logic [ARB_N-1:0]   req;
  logic [ARB_N-1:0]   gnt;
  logic               gnt_valid;
  logic [ARB_IDW-1:0] gnt_id;

  modport master (output req, input gnt, input gnt_valid, input gnt_id);
  modport slave  (input req, output gnt, output gnt_valid, output gnt_id);
endinterface

// File: rtl/student_or8way.sv
// rtl/student_or8way.sv - 8-input OR gate from the gate library, built as a 2-input OR tree
// Ports: a[7:0] inputs, y output (1 when any input bit is set).
module student_or8way (
  input  logic [7:0] a,
  output logic       y
);
  logic [3:0] l1;
  logic [1:0] l2;

  assign l1 = a[7:4] | a[3:0];
  assign l2 = l1[3:2] | l1[1:0];
  assign y  = l2[1] | l2[0];
endmodule

// File: rtl/student_rr_pick.sv
// rtl/student_rr_pick.sv - combinational round-robin picker: rotate, fixed-priority pick, un-rotate
// Ports: req[7:0] candidates, ptr[2:0] last owner; pick_oh[7:0] one-hot winner,
//        pick_id[2:0] winner index (0 when none), pick_any any candidate present.
module student_rr_pick
  import student_arb_pkg::*;
(
  input  logic [ARB_N-1:0]   req,
  input  logic [ARB_IDW-1:0] ptr,
  output logic [ARB_N-1:0]   pick_oh,
  output logic [ARB_IDW-1:0] pick_id,
  output logic               pick_any
);
  logic [ARB_IDW-1:0] start;
  logic [ARB_N-1:0]   rot;
  logic [ARB_IDW-1:0] rot_k;
  logic               found;

  // Search begins one past the last owner; 3-bit arithmetic gives the 7->0 wrap.
  assign start = ptr + 3'd1;

  always_comb begin
    rot     = '0;
    rot_k   = '0;
    found   = 1'b0;
    pick_oh = '0;
    pick_id = '0;
    // rot[0] is the highest-priority candidate for this ptr
    for (int i = 0; i < ARB_N; i++) begin
      rot[i] = req[start + ARB_IDW'(i)];
    end
    for (int i = 0; i < ARB_N; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        rot_k = ARB_IDW'(i);
      end
    end
    if (found) begin
      pick_id          = start + rot_k;
      pick_oh[pick_id] = 1'b1;
    end
  end

  student_or8way u_any (
    .a (req),
    .y (pick_any)
  );
endmodule

// File: rtl/student_rr_arb8.sv
// rtl/student_rr_arb8.sv - 8-requester round-robin arbiter with registered one-hot grant
// Ports: clk, reset_n (async, active-low), bus (student_rr_arb8_if.slave: req in; gnt, gnt_valid, gnt_id out).
// Option: STUDENT_ARB_HOLD_LIMIT_EN adds a hold counter forcing rotation after MAX_HOLD grant cycles
//         when another requester is waiting.
module student_rr_arb8
  import student_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  student_rr_arb8_if.slave   bus
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("MAX_HOLD must be within 2..255");
  end

  arb_state_e         state_q, state_d;
  logic [ARB_IDW-1:0] ptr_q, ptr_d;
  logic [ARB_N-1:0]   gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [ARB_IDW-1:0] id_q, id_d;

  logic [ARB_N-1:0]   pick_req;
  logic [ARB_IDW-1:0] pick_ptr;
  logic [ARB_N-1:0]   pick_oh;
  logic [ARB_IDW-1:0] pick_id;
  logic               pick_any;
  logic               owner_req;
  logic               force_rot;

`ifdef STUDENT_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // While granted, the picker sees only the other requesters and searches from
  // the current owner, which is exactly the order a release would use.
  always_comb begin
    pick_req = bus.req;
    pick_ptr = ptr_q;
    if (state_q == ST_GRANT) begin
      pick_req = bus.req & ~gnt_q;
      pick_ptr = id_q;
    end
  end

  student_rr_pick u_pick (
    .req      (pick_req),
    .ptr      (pick_ptr),
    .pick_oh  (pick_oh),
    .pick_id  (pick_id),
    .pick_any (pick_any)
  );

  assign owner_req = bus.req[id_q];

`ifdef STUDENT_ARB_HOLD_LIMIT_EN
  assign force_rot = (cnt_q == HOLD_LAST) && pick_any;
`else
  assign force_rot = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    id_d    = id_q;
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = pick_oh;
          valid_d = 1'b1;
          id_d    = pick_id;
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        if (owner_req && !force_rot) begin
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
          // saturate so a lone owner keeps the grant and rotation fires as soon as someone arrives
          if (cnt_q != HOLD_LAST) cnt_d = cnt_q + 8'd1;
`endif
        end else begin
          ptr_d = id_q;
          if (pick_any) begin
            gnt_d = pick_oh;
            id_d  = pick_id;
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
            cnt_d = 8'd0;
`endif
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            id_d    = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd7;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_id    = id_q;
endmodule

// File: tb/tb_student_rr_arb8.sv
// tb/tb_student_rr_arb8.sv - scoreboard bench for student_rr_arb8 against a rotation-rule reference model
module tb_student_rr_arb8;
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
  localparam int MAX_HOLD = 4;
`else
  localparam int MAX_HOLD = 16;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  student_rr_arb8_if ifc ();

  student_rr_arb8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  typedef struct {
    logic [7:0] gnt;
    logic       v;
    logic [2:0] id;
  } exp_t;

  exp_t exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  // reference model: last owner, current owner (-1 = none), cycles the current owner has held
  int m_ptr, m_owner, m_ten;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_ptr = 7; m_owner = -1; m_ten = 0;
  endfunction

  function automatic int search(input logic [7:0] r, input int base, input int excl);
    for (int k = 1; k <= 8; k++) begin
      int idx = (base + k) % 8;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [7:0] r);
    if (m_owner >= 0) begin
      bit rel = !r[m_owner];
`ifdef STUDENT_ARB_HOLD_LIMIT_EN
      if (!rel && m_ten >= MAX_HOLD && search(r, m_owner, m_owner) >= 0) rel = 1;
`endif
      if (!rel) m_ten++;
      else begin
        m_ptr   = m_owner;
        m_owner = search(r, m_ptr, m_ptr);
        m_ten   = 1;
      end
    end else begin
      m_owner = search(r, m_ptr, -1);
      m_ten   = 1;
    end
  endfunction

  task automatic step(input logic [7:0] r);
    exp_t e;
    @(negedge clk);
    ifc.req = r;
    model_step(r);
    e.v   = (m_owner >= 0);
    e.gnt = e.v ? (8'b1 << m_owner) : 8'h00;
    e.id  = e.v ? 3'(m_owner) : 3'd0;
    exp_q.push_back(e);
  endtask

  // monitor: pop the expectation for each edge and check structural invariants
  logic [7:0] prev_gnt = 8'h00;
  int wait_cnt[8];
  always begin
    exp_t e;
    int maxw;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt", ifc.gnt, e.gnt);
      chk("gnt_valid", ifc.gnt_valid, e.v);
      chk("gnt_id", ifc.gnt_id, e.id);
    end
    chk("onehot0", $onehot0(ifc.gnt), 1);
    chk("id_vs_gnt", ifc.gnt, ifc.gnt_valid ? (8'b1 << ifc.gnt_id) : 8'h00);
    for (int i = 0; i < 8; i++) if (!ifc.req[i] || ifc.gnt[i]) wait_cnt[i] = 0;
    if (ifc.gnt != 8'h00 && ifc.gnt != prev_gnt) begin
      maxw = 0;
      for (int i = 0; i < 8; i++) begin
        if (ifc.req[i] && !ifc.gnt[i]) wait_cnt[i]++;
        if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
      end
      n_total++;
      if (maxw <= 7) n_pass++;
      else $display("FAIL wait_bound: got %0d tenures waited, limit 7", maxw);
    end
    prev_gnt = ifc.gnt;
  end

  initial begin
    logic [7:0] r;
    ifc.req = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_gnt", ifc.gnt, 8'h00);
    chk("reset_valid", ifc.gnt_valid, 1'b0);
    chk("reset_id", ifc.gnt_id, 3'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single requester: grant, hold 5, release
    repeat (6) step(8'h01);
    repeat (2) step(8'h00);

    // all requesting; each owner drops for one cycle in turn
    step(8'hFF);
    for (int n = 0; n < 9; n++) begin
      step(8'hFF & ~(8'b1 << m_owner));
      step(8'hFF);
    end
    repeat (2) step(8'h00);

    // zero-bubble handoff 3 -> 5, re-raised 3 waits for 5
    step(8'h08);
    step(8'h28);
    step(8'h20);
    step(8'h28);
    step(8'h28);
    step(8'h08);
    step(8'h08);
    step(8'h00);

    // asynchronous reset mid-grant
    step(8'h50);
    step(8'h50);
    @(posedge clk); #3;
    reset_n = 1'b0;
    ifc.req = 8'h00;
    #1;
    chk("async_gnt", ifc.gnt, 8'h00);
    chk("async_valid", ifc.gnt_valid, 1'b0);
    chk("async_id", ifc.gnt_id, 3'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h50);
    step(8'h50);
    step(8'h00);

    // two holders, then a lone holder
    repeat (12) step(8'h03);
    repeat (10) step(8'h01);
    step(8'h00);

    // random traffic: requests persist until dropped at random
    r = 8'h00;
    repeat (10000) begin
      for (int i = 0; i < 8; i++) begin
        if (r[i]) begin
          if ($urandom_range(7) == 0) r[i] = 1'b0;
        end else if ($urandom_range(3) == 0) r[i] = 1'b1;
      end
      step(r);
    end
    repeat (2) step(8'h00);

    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
